astropix3_spi_readout_sequencer: RTL

- Host-side SPI master that drains frames from the Astropix3 ASIC (or its RTL model) egress FIFO.
- Watches the active-low interrupt, opens an SPI transaction and clocks out idle bytes on MOSI while assembling MISO bytes.
- Filters idle filler and pushes payload bytes to a downstream readout FIFO through a valid/ready handshake.
- Sits between the ASIC SPI pins and the firmware readout buffer.

---
 rtl/astropix3_spi_readout_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/astropix3_spi_readout_sequencer.sv
// Astropix3 SPI readout sequencer: drains the ASIC egress FIFO over SPI
// mode 0 and forwards received bytes through a valid/ready port.
module astropix3_spi_readout_sequencer #(
    parameter logic [7:0] IDLE_BYTE  = 8'hBC,
    parameter int         TRAIL_IDLE = 4,
    parameter int         MAX_BYTES  = 1024,
    parameter int         CS_GAP     = 8
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        enable,
    input  logic        force_read,
    input  logic        drop_idle,
    input  logic [7:0]  clk_div,
    input  logic        interruptn,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic [1:0]  spi_miso,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] last_count,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_PUSH, S_EVAL, S_RELEASE
    } state_t;

    state_t      r_state, w_next;
    logic        r_irq_meta, r_irq_sync;
    logic [7:0]  r_div, r_hcnt, r_shift, r_data, r_idle_run, r_gap;
    logic [3:0]  r_bit;
    logic [15:0] r_byte_cnt, r_last;
    logic        r_csn, r_sclk, r_mosi, r_valid, r_timeout;

    logic        w_irq, w_tick, w_start, w_is_idle, w_end, w_pushed;
    logic        w_gap_done, w_byte_done;
    logic [2:0]  w_mosi_idx;
    logic        w_unused_miso;

    assign w_unused_miso = spi_miso[1];
    assign w_irq       = !r_irq_sync;
    assign w_tick      = (r_hcnt == r_div - 8'd1);
    assign w_start     = (enable && w_irq) || force_read;
    assign w_is_idle   = (r_shift == IDLE_BYTE);
    assign w_pushed    = !r_valid || out_ready;
    assign w_gap_done  = (r_gap == 8'(CS_GAP - 1));
    assign w_byte_done = w_tick && r_sclk && (r_bit == 4'd8);
    // r_bit counts rising edges seen; 8 wraps to bit 7 for the next byte
    assign w_mosi_idx  = 3'(4'd7 - r_bit);
    assign w_end       = ((r_idle_run >= 8'(TRAIL_IDLE)) && !w_irq)
                       || (r_byte_cnt == 16'(MAX_BYTES));

    assign spi_csn    = r_csn;
    assign spi_clk    = r_sclk;
    assign spi_mosi   = r_mosi;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign busy       = (r_state != S_IDLE);
    assign last_count = r_last;
    assign timeout    = r_timeout;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_irq_meta <= 1'b1;
            r_irq_sync <= 1'b1;
        end else begin
            r_irq_meta <= interruptn;
            r_irq_sync <= r_irq_meta;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_next = S_SETUP;
            S_SETUP:   if (w_tick) w_next = S_SHIFT;
            S_SHIFT:   if (w_byte_done) w_next = S_PUSH;
            S_PUSH:    if (w_pushed) w_next = S_EVAL;
            S_EVAL:    w_next = w_end ? S_RELEASE : S_SHIFT;
            S_RELEASE: if (w_gap_done) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_div      <= 8'd1;
            r_hcnt     <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_idle_run <= '0;
            r_gap      <= '0;
            r_bit      <= '0;
            r_byte_cnt <= '0;
            r_last     <= '0;
            r_csn      <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div  <= (clk_div == 8'd0) ? 8'd1 : clk_div;
                    r_hcnt <= '0;
                    r_bit  <= '0;
                    if (w_start) begin
                        r_csn  <= 1'b0;
                        r_mosi <= IDLE_BYTE[7];
                        if (force_read) r_timeout <= 1'b0;
                    end
                end
                S_SETUP: r_hcnt <= w_tick ? 8'd0 : r_hcnt + 8'd1;
                S_SHIFT: begin
                    if (!w_tick) begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end else begin
                        r_hcnt <= '0;
                        r_sclk <= !r_sclk;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[6:0], spi_miso[0]};
                            r_bit   <= r_bit + 4'd1;
                        end else begin
                            r_mosi <= IDLE_BYTE[w_mosi_idx];
                            if (r_bit == 4'd8) begin
                                r_bit <= '0;
                                if (!(drop_idle && w_is_idle)) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_PUSH: begin
                    if (w_pushed) begin
                        r_valid <= 1'b0;
                        if (r_byte_cnt != 16'hFFFF)
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                        if (!w_is_idle)
                            r_idle_run <= '0;
                        else if (r_idle_run != 8'hFF)
                            r_idle_run <= r_idle_run + 8'd1;
                    end
                end
                S_EVAL: begin
                    if (w_end) begin
                        r_csn      <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_last     <= r_byte_cnt;
                        r_byte_cnt <= '0;
                        r_idle_run <= '0;
                        r_gap      <= '0;
                        if (r_byte_cnt == 16'(MAX_BYTES)) r_timeout <= 1'b1;
                    end
                end
                S_RELEASE: r_gap <= r_gap + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
